// File: rtl/inst_prefetch_buf.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buf
//
// Instruction prefetch queue that sits between the instruction memory and the
// IF stage of the pipelined CPU. It drives the fetch address, captures each
// instruction returned for that address (together with its PC) into a small
// FIFO, and presents the oldest entry to IF. A redirect from the CPU flushes
// the queue and restarts fetch at the new target.
//
// Optional feature (compile-time macro PREFETCH_BYPASS_EN):
//   When the queue is empty and no redirect is pending, the instruction being
//   fetched this cycle is offered to IF combinationally. If IF takes it, it is
//   never written into the queue.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   pf_pc        out  [WORD]       address to instruction memory (= fetch_pc)
//   pf_inst      in   [INST_SIZE]  instruction returned for pf_pc, same cycle
//   redirect     in   flush queue and restart fetch at redirect_pc
//   redirect_pc  in   [WORD]       new fetch target (low two bits ignored)
//   deq_ready    in   IF accepts the head entry this cycle
//   inst_valid   out  head entry valid
//   inst_out     out  [INST_SIZE]  head instruction (0 when empty)
//   inst_pc      out  [WORD]       PC of the head instruction (0 when empty)
//   count        out  [$clog2(DEPTH)+1] current occupancy
//
// Handshake: the head entry transfers to IF on a clock edge where
// inst_valid=1, deq_ready=1 and redirect=0. inst_valid never depends on
// deq_ready; deq_ready may be held high while the queue is empty.
// ---------------------------------------------------------------------------
module inst_prefetch_buf #(
  parameter int                WORD      = 64,
  parameter int                INST_SIZE = 32,
  parameter int                DEPTH     = 4,
  parameter logic [WORD-1:0]   RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [WORD-1:0]            pf_pc,
  input  logic [INST_SIZE-1:0]       pf_inst,
  input  logic                       redirect,
  input  logic [WORD-1:0]            redirect_pc,
  input  logic                       deq_ready,
  output logic                       inst_valid,
  output logic [INST_SIZE-1:0]       inst_out,
  output logic [WORD-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [WORD-1:0] PC_STEP = WORD'(4);

  logic [WORD-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WORD-1:0]      mem_pc_q   [DEPTH];
  logic [WORD-1:0]      mem_pc_d   [DEPTH];
  logic [INST_SIZE-1:0] mem_inst_q [DEPTH];
  logic [INST_SIZE-1:0] mem_inst_d [DEPTH];

  logic empty;
  logic full;
  logic deq;
  logic enq;
  logic byp_take;

  // Alignment drops redirect_pc[1:0]; tie them off explicitly.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pf_pc = fetch_pc_q;
  assign count = count_q;

  // Queue pop: only real stored entries are dequeued; redirect wins.
  assign deq = ~empty & deq_ready & ~redirect;

`ifdef PREFETCH_BYPASS_EN
  // Empty queue and IF ready: the instruction in flight is handed straight
  // through and never stored.
  assign byp_take = empty & ~redirect & deq_ready;
`else
  assign byp_take = 1'b0;
`endif

  // A full queue can still accept when it is popping in the same cycle.
  assign enq = ~redirect & (~full | deq) & ~byp_take;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;

    if (redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[WORD-1:2], 2'b00};
    end else begin
      if (enq) begin
        mem_pc_d[wr_ptr_q]   = fetch_pc_q;
        mem_inst_d[wr_ptr_q] = pf_inst;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        fetch_pc_d           = fetch_pc_q + PC_STEP;
      end
      if (byp_take) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

  // -------------------------------------------------------------------------
  // Head outputs (first-word fall-through, zero when empty)
  // -------------------------------------------------------------------------
  always_comb begin
    inst_valid = ~empty;
    inst_out   = '0;
    inst_pc    = '0;
    if (!empty) begin
      inst_out = mem_inst_q[rd_ptr_q];
      inst_pc  = mem_pc_q[rd_ptr_q];
    end
`ifdef PREFETCH_BYPASS_EN
    // Reset gates the pass-through so the head reads as empty immediately.
    if (empty && !redirect && !rst) begin
      inst_valid = 1'b1;
      inst_out   = pf_inst;
      inst_pc    = fetch_pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_buf
//
// Directed + randomized bench for inst_prefetch_buf. The memory is a pure
// function of the address. The reference is an expected queue of PCs plus a
// fetch address, updated from the queue rules each cycle.
// ---------------------------------------------------------------------------
module tb_inst_prefetch_buf;

  localparam int WORD      = 64;
  localparam int INST_SIZE = 32;
  localparam int DEPTH     = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [WORD-1:0]      pf_pc;
  logic [INST_SIZE-1:0] pf_inst;
  logic                 redirect;
  logic [WORD-1:0]      redirect_pc;
  logic                 deq_ready;
  logic                 inst_valid;
  logic [INST_SIZE-1:0] inst_out;
  logic [WORD-1:0]      inst_pc;
  logic [2:0]           count;

  function automatic logic [INST_SIZE-1:0] mem_f(input logic [WORD-1:0] a);
    return (32'h8B00_0000 + a[31:0]) ^ a[63:32];
  endfunction

  assign pf_inst = mem_f(pf_pc);

  inst_prefetch_buf #(
    .WORD(WORD), .INST_SIZE(INST_SIZE), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst), .pf_pc(pf_pc), .pf_inst(pf_inst),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [WORD-1:0] exp_q[$];
  logic [WORD-1:0] m_fetch;
  int n_pass;
  int n_fail;
  int n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare head outputs/occupancy against the expected queue.
  task automatic model_check();
    logic            e_valid;
    logic [WORD-1:0] e_pc;
    e_valid = (exp_q.size() != 0);
    e_pc    = e_valid ? exp_q[0] : '0;
`ifdef PREFETCH_BYPASS_EN
    if (!e_valid && !redirect) begin
      e_valid = 1'b1;
      e_pc    = m_fetch;
    end
`endif
    chk("inst_valid", 64'(inst_valid), 64'(e_valid));
    chk("inst_pc", inst_pc, e_pc);
    chk("inst_out", 64'(inst_out), e_valid ? 64'(mem_f(e_pc)) : 64'd0);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("pf_pc", pf_pc, m_fetch);
  endtask

  // Apply one clock edge of the queue rules to the model.
  task automatic model_update();
    logic take;
    logic room;
    if (redirect) begin
      exp_q.delete();
      m_fetch = {redirect_pc[WORD-1:2], 2'b00};
    end else begin
`ifdef PREFETCH_BYPASS_EN
      if (exp_q.size() == 0 && deq_ready) begin
        m_fetch = m_fetch + 64'd4;
      end else begin
`endif
        take = (exp_q.size() != 0) && deq_ready;
        room = (exp_q.size() < DEPTH) || take;
        if (take) void'(exp_q.pop_front());
        if (room) begin
          exp_q.push_back(m_fetch);
          m_fetch = m_fetch + 64'd4;
        end
`ifdef PREFETCH_BYPASS_EN
      end
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic dr, input logic rd, input logic [WORD-1:0] rpc);
    deq_ready   = dr;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic dr, input logic rd, input logic [WORD-1:0] rpc);
    drive(dr, rd, rpc);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_fetch = '0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_pf_pc", pf_pc, 64'd0);
    chk("rst_inst_out", 64'(inst_out), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with IF always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0);
`ifdef PREFETCH_BYPASS_EN
      if (i < 4) begin
        chk("stream_pc", inst_pc, 64'(4 * i));
        chk("stream_cnt", 64'(count), 64'd0);
      end
`else
      if (i >= 1 && i <= 4) begin
        chk("stream_pc", inst_pc, 64'(4 * (i - 1)));
        chk("stream_cnt", 64'(count), 64'd1);
      end
`endif
      tick();
    end

    // Fill: restart at 0, IF stalled for 6 cycles.
    step(1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    chk("full_pf_pc", pf_pc, 64'd16);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1'b1, 1'b0, '0);
      chk("drain_pc", inst_pc, 64'(4 * i));
      chk("drain_cnt", 64'(count), 64'd4);
      tick();
    end

    // Redirect with PCs 8,12,16 queued.
    step(1'b0, 1'b1, 64'h8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 64'h103);
    chk("redir_pre_cnt", 64'(count), 64'd3);
    chk("redir_pre_pc", inst_pc, 64'd8);
    tick();
    drive(1'b0, 1'b0, '0);
    chk("redir_cnt", 64'(count), 64'd0);
    chk("redir_pf_pc", pf_pc, 64'h100);
    tick();
    drive(1'b0, 1'b0, '0);
    chk("redir_valid", 64'(inst_valid), 64'd1);
    chk("redir_inst_pc", inst_pc, 64'h100);
    tick();

    // Redirect wins over deq_ready on a full queue.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 64'h400);
    chk("rfull_pre_cnt", 64'(count), 64'd4);
    tick();
    drive(1'b0, 1'b0, '0);
    chk("rfull_cnt", 64'(count), 64'd0);
    chk("rfull_pf_pc", pf_pc, 64'h400);
    tick();

    // Pointer wrap with alternating deq_ready.
    for (int i = 0; i < 10; i++) step(1'((i % 2) == 1), 1'b0, '0);

`ifdef PREFETCH_BYPASS_EN
    step(1'b0, 1'b1, 64'h200);
    drive(1'b1, 1'b0, '0);
    chk("byp_valid", 64'(inst_valid), 64'd1);
    chk("byp_inst_pc", inst_pc, 64'h200);
    tick();
`endif

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           {32'($urandom), 32'($urandom)});
    end

    // Asynchronous reset with three entries queued.
    step(1'b0, 1'b1, 64'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    chk("mid_pre_cnt", 64'(count), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_pf_pc", pf_pc, 64'd0);
    chk("mid_rst_inst_pc", inst_pc, 64'd0);
    exp_q.delete();
    m_fetch = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_buf.md
Name: inst_prefetch_buf

Overview:
- Instruction prefetch queue between the instruction memory and the pipelined CPU's IF stage.
- Drives the instruction address, captures each returned instruction with its PC into a small FIFO, and presents the oldest entry to IF.
- Decouples IF stalls from memory fetch.
- Flushes and refetches on a branch or jump redirect from the CPU.

Parameters:
- WORD, 64, PC/address width in bits.
- INST_SIZE, 32, instruction width in bits.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- pf_pc  output  WORD  address to the instruction memory.
- pf_inst  input  INST_SIZE  instruction returned combinationally for pf_pc in the same cycle.
- redirect  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  WORD  new fetch target.
- deq_ready  input  1  IF stage accepts the head entry this cycle.
- inst_valid  output  1  head entry valid.
- inst_out  output  INST_SIZE  head instruction.
- inst_pc  output  WORD  PC of the head instruction.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - fetch_pc register.
  - DEPTH-entry storage of {pc, inst}.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- pf_pc = fetch_pc at all times, combinationally.
- Reset (asynchronous, any time, including mid-flush):
  - fetch_pc=RESET_PC; wr_ptr=rd_ptr=0; count=0.
  - inst_valid=0, inst_out=0, inst_pc=0.
  - Storage contents need not be cleared.
- Head outputs:
  - inst_valid = (count!=0).
  - inst_out and inst_pc are driven from entry rd_ptr when valid, and are 0 when empty (first-word fall-through).
- deq = inst_valid & deq_ready & ~redirect.
- enq = ~redirect & (count<DEPTH | deq).
  - A full queue still accepts a new entry in the same cycle as a dequeue.
- On a clock edge with enq:
  - Entry[wr_ptr] <= {fetch_pc, pf_inst}.
  - wr_ptr += 1.
  - fetch_pc += 4, wrapping modulo 2^WORD.
- On a clock edge with deq: rd_ptr += 1.
- count update:
  - +1 if enq only; -1 if deq only; unchanged if both or neither.
  - Never exceeds DEPTH and never goes below 0.
- On a clock edge with redirect:
  - wr_ptr=rd_ptr=0; count=0.
  - fetch_pc <= {redirect_pc[WORD-1:2], 2'b00}; the low two bits are ignored.
  - No enqueue and no dequeue that cycle; redirect has priority over deq_ready.
- Full queue, no deq: fetch_pc holds and pf_pc is stable.
- Empty queue with deq_ready=1: nothing happens.
- Latency:
  - Instruction at fetch_pc appears on inst_out one cycle after it is requested.
  - After a redirect, the first valid instruction appears 2 edges after redirect is sampled.
- Throughput: 1 instruction/cycle in steady state when deq_ready is held high.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When count==0 and redirect=0, inst_valid=1, inst_out=pf_inst, inst_pc=fetch_pc, all combinationally.
  - If deq_ready=1 in that cycle, the instruction is consumed without being written.
    - fetch_pc += 4; pointers and count unchanged.
    - enq is suppressed for that instruction.
  - Redirect-to-first-valid latency drops to 1 edge.
- Not defined: the empty queue gives inst_valid=0, and the behaviour is exactly as above.

Test Plan:
- Reset: rst=1 mid-operation with count=3 -> count=0, inst_valid=0, pf_pc=RESET_PC immediately, without waiting for a clock edge.
- Streaming: RESET_PC=0, deq_ready=1, memory returns 0x8B000000+addr -> inst_pc sequence 0,4,8,12 on consecutive cycles after the first-valid cycle; count stays at 1.
- Fill/full: deq_ready=0 for 6 cycles -> count reaches 4 and pf_pc holds at 16.
  - Then deq_ready=1 -> entries dequeued in order 0,4,8,12 and enqueue continues at 16 in the same cycle.
- Redirect: queue holding PCs 8,12,16 and redirect=1 with redirect_pc=0x103 -> next cycle count=0 and pf_pc=0x100; following cycle inst_valid=1, inst_pc=0x100.
- Redirect with deq_ready=1 and a full queue in the same cycle -> no dequeue is counted, queue empties, fetch restarts at the target.
- Pointer wrap: 10 enq/deq cycles with alternating deq_ready -> PCs are delivered strictly in order with no duplicates or gaps across the pointer wrap.
  - With PREFETCH_BYPASS_EN defined, redirect to 0x200 -> inst_valid=1, inst_pc=0x200 one edge after redirect is sampled.
